// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and the backward Rcon step.
package aes_pkg;

  localparam int          AES_NR    = 10;
  localparam logic [7:0]  RCON_LAST = 8'h36;
  localparam logic [8:0]  GF_POLY   = 9'h11b;
  localparam int          RND_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Divide an Rcon value by x in GF(2^8): undo the forward xtime step.
  function automatic logic [7:0] rcon_div_x(input logic [7:0] r);
    logic [8:0] t;
    t = r[0] ? ({1'b0, r} ^ GF_POLY) : {1'b0, r};
    return t[8:1];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte in, one byte out).
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: takes the round-10 key and streams round
// keys 10..0 over a valid/ready handshake, deriving each earlier key on the
// fly. Optional macro AES_INV_KEY_SCHED_ABORT_EN adds an abort input that
// ends a sequence early.
module aes_inv_key_sched #(
  parameter int         NR        = aes_pkg::AES_NR,
  parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
`ifdef AES_INV_KEY_SCHED_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      in_ready,
  input  logic [127:0]              in_key,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [127:0]              rk,
  output logic [aes_pkg::RND_W-1:0] rk_round,
  output logic                      busy
);

  import aes_pkg::*;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_rk_valid;
  logic             r_busy;
  logic [127:0]     r_rk;
  logic [RND_W-1:0] r_rk_round;
  logic [7:0]       r_rcon;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot, w_sub;
  logic [127:0] w_prev_key;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;

  // Undo the forward expansion: each word XORs with its left neighbour,
  // and word 0 removes the SubWord/RotWord/Rcon term of the recovered w3.
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[g*8 +: 8]),
      .o_byte (w_sub[g*8 +: 8])
    );
  end

  assign w_p0       = w_w0 ^ w_sub ^ {r_rcon, 24'h0};
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  // Handshake FSM with registered outputs; steps key, round and Rcon together.
  // NOTE: all state here uses <= so every register samples pre-edge values;
  // a blocking = would let later statements see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_rk       <= '0;
      r_rk_round <= '0;
      r_rcon     <= RCON_LAST;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rk       <= in_key;
            r_rk_round <= RND_W'(NR);
            r_rcon     <= RCON_LAST;
            r_state    <= EMIT;
            r_in_ready <= 1'b0;
            r_rk_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        EMIT: begin
`ifdef AES_INV_KEY_SCHED_ABORT_EN
          if (abort) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
          end else
`endif
          if (rk_ready) begin
            if (r_rk_round == '0) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_rk       <= w_prev_key;
              r_rk_round <= r_rk_round - 1'b1;
              r_rcon     <= rcon_div_x(r_rcon);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign rk_valid = r_rk_valid;
  assign busy     = r_busy;
  assign rk       = r_rk;
  assign rk_round = r_rk_round;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 AES-128 key.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
`ifdef AES_INV_KEY_SCHED_ABORT_EN
  logic         abort;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] exp_rk   [0:10];
  logic [7:0]   exp_rcon [1:10];
  logic [127:0] other_key;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .in_ready (in_ready),
    .in_key   (in_key),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a key in IDLE and confirm rk_valid the following cycle.
  task automatic load(input logic [127:0] k);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("load_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_key   = k;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_rk_valid", rk_valid, 1);
    check("load_round", rk_round, 10);
    check("load_key", rk, k);
  endtask

  // Walk the stream from round 10 until round stop_at is next on rk.
  task automatic run_seq(input int stop_at, input bit bp, input bit probe);
    int  r   = 10;
    int  cyc = 0;
    bit  rdy;
    while (r > stop_at && cyc < 400) begin
      @(negedge clk);
      cyc++;
      check("rk_valid", rk_valid, 1);
      check($sformatf("rk_r%0d", r), rk, exp_rk[r]);
      check("rk_round", rk_round, r);
      if (probe && r > 0) check($sformatf("rcon_r%0d", r), dut.r_rcon, exp_rcon[r]);
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (rdy) r--;
    end
    if (cyc >= 400) check("seq_timeout", 0, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic full_seq(input bit bp, input bit probe);
    run_seq(-1, bp, probe);
    @(negedge clk);
    rk_ready = 1'b0;
    check_idle("end");
    check("end_rk_hold", rk, exp_rk[0]);
  endtask

  initial begin
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rcon[10] = 8'h36; exp_rcon[9] = 8'h1b; exp_rcon[8] = 8'h80;
    exp_rcon[7]  = 8'h40; exp_rcon[6] = 8'h20; exp_rcon[5] = 8'h10;
    exp_rcon[4]  = 8'h08; exp_rcon[3] = 8'h04; exp_rcon[2] = 8'h02;
    exp_rcon[1]  = 8'h01;
    other_key = 128'h000102030405060708090a0b0c0d0e0f;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_key   = '0;
    rk_ready = 1'b0;
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    abort    = 1'b0;
`endif
    #12;
    check_idle("reset");
    check("reset_rk", rk, 0);
    check("reset_round", rk_round, 0);
    check("reset_rcon", dut.r_rcon, 8'h36);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sequence, ready held high, with Rcon probe.
    load(exp_rk[10]);
    full_seq(1'b0, 1'b1);

    // rk_ready while idle must not start anything.
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    rk_ready = 1'b0;
    check_idle("idle_ready");
    check("idle_ready_rk", rk, exp_rk[0]);

    // Random backpressure.
    load(exp_rk[10]);
    full_seq(1'b1, 1'b1);

    // in_valid held with a different key during EMIT.
    load(exp_rk[10]);
    in_valid = 1'b1;
    in_key   = other_key;
    run_seq(-1, 1'b1, 1'b0);
    @(negedge clk);
    rk_ready = 1'b0;
    check_idle("iv_end");
    @(negedge clk);
    in_valid = 1'b0;
    check("iv_second_valid", rk_valid, 1);
    check("iv_second_key", rk, other_key);
    check("iv_second_round", rk_round, 10);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    // Asynchronous reset at round 5, then a clean reload.
    load(exp_rk[10]);
    run_seq(5, 1'b0, 1'b0);
    @(negedge clk);
    rk_ready = 1'b0;
    check("pre_reset_round", rk_round, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_rk", rk, 0);
    check("async_rst_round", rk_round, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rk_valid", rk_valid, 0);
    load(exp_rk[10]);
    full_seq(1'b0, 1'b1);

`ifdef AES_INV_KEY_SCHED_ABORT_EN
    // Abort at round 7 wins over a simultaneous accept.
    load(exp_rk[10]);
    run_seq(7, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_abort_round", rk_round, 7);
    abort    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    rk_ready = 1'b0;
    check_idle("abort");
    check("abort_round", rk_round, 7);
    check("abort_rk", rk, exp_rk[7]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_idle");
    load(exp_rk[10]);
    full_seq(1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Inverse AES-128 key schedule for the decryption datapath.
- Accepts the final (round-10) round key and streams round keys 10, 9, … 0 one per handshake, computing each earlier key on the fly.
- Steps the round constant backwards (0x36 → 0x1b → 0x80 → … → 0x01) by GF(2^8) division by x, not by table lookup.
- Sits between the key-load register and the inverse cipher round engine.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128 (other values unsupported).
- RCON_LAST, 8'h36, round constant of round NR; starting point of the backward Rcon walk.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  round-10 key offered.
- in_ready  output  1  block idle and able to accept a key.
- in_key  input  128  round-10 key, word 0 in bits [127:96].
- rk_valid  output  1  round key on rk is valid.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk  output  128  current round key, same word order as in_key.
- rk_round  output  4  round index of rk (10 down to 0).
- busy  output  1  high whenever not IDLE.

Behaviour:
- States: IDLE and EMIT.
- Reset values (asynchronous):
  - State = IDLE, in_ready = 1, rk_valid = 0, busy = 0.
  - rk = 0, rk_round = 0, internal rcon = RCON_LAST.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: rk <= in_key, rk_round <= 10, rcon <= 8'h36, state <= EMIT.
  - rk_valid rises the next cycle (1-cycle latency).
- EMIT:
  - in_ready = 0 and rk_valid = 1.
  - rk, rk_round and rk_valid are held stable while rk_ready = 0.
  - in_valid is ignored.
- Accept in EMIT with rk_round > 0:
  - rk <= previous key; rk_round <= rk_round - 1.
  - rcon <= rcon[0] ? ((rcon ^ 9'h11b) >> 1) : (rcon >> 1).
  - Stay in EMIT. Back-to-back accepts give one key per cycle.
- Previous-key arithmetic, with current words w0..w3:
  - p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - Uses the forward S-box; the path is combinational within one cycle.
- Accept in EMIT with rk_round == 0:
  - state <= IDLE, rk_valid <= 0.
  - rk holds the round-0 key (not cleared).
  - in_ready = 1 the next cycle. A new key cannot be accepted in the same cycle as the final accept.
- Complete sequence = 11 beats. The rcon value in use at round r equals the forward Rcon of round r.
- Reset mid-sequence: outputs return to reset values immediately. No partial key is emitted after reset release.
- rk_ready while rk_valid = 0: no effect.

Optional Feature:
- Macro: AES_INV_KEY_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in EMIT: state <= IDLE and rk_valid <= 0 on the next edge.
  - abort takes priority over a simultaneous rk_ready accept.
  - in_ready = 1 the following cycle.
  - abort in IDLE is ignored.
- Undefined: no abort port; the only way to end a sequence early is rst_n.

Decomposition:
- Shared package/header aes_pkg holds:
  - AES_NR = 10, RCON_LAST = 8'h36, GF reduction polynomial 9'h11b.
  - The 4-bit round index width.
  - State encodings IDLE/EMIT.
- One natural sub-module: aes_sbox (combinational 8-bit forward S-box).
  - Instantiated 4 times for SubWord; shared with the encryption key expansion and SubBytes.

Test Plan:
- FIPS-197 vector, rk_ready held 1: load d014f9a8c9ee2589e13f0cc8b6630ca6 → rk_valid from the next cycle.
  - Beat 1 = same key with rk_round 10.
  - Beat 2 = ac7766f319fadc2128d12941575c006e with rk_round 9.
  - Beat 11 = 2b7e151628aed2a6abf7158809cf4f3c with rk_round 0.
  - Then rk_valid = 0, in_ready = 1.
- Backpressure: same load, rk_ready toggled randomly → identical 11-key sequence; rk and rk_round stable during every rk_ready = 0 cycle.
- Rcon walk: probe the internal rcon across the sequence → 36,1b,80,40,20,10,08,04,02,01 for rounds 10..1.
- in_valid asserted throughout EMIT with a different key → ignored; sequence unchanged; the second key is accepted only after the round-0 accept.
- rst_n pulsed low at round 5 → rk_valid = 0, in_ready = 1 asynchronously; a reload after release gives a correct full sequence from round 10.
- With AES_INV_KEY_SCHED_ABORT_EN: abort with rk_ready = 1 at round 7 → no round-6 beat; IDLE next cycle; a subsequent load gives a correct sequence.
